// File: rtl/rps_pkg.sv
// Shared move/result codes, FSM states and move count for the RPS match.
// RPS_LIZARD_SPOCK_EN adds spock/lizard and switches to the 5-move rule.
package rps_pkg;

  localparam logic [2:0] MV_ROCK     = 3'd0;
  localparam logic [2:0] MV_PAPER    = 3'd1;
  localparam logic [2:0] MV_SCISSORS = 3'd2;
  localparam logic [2:0] MV_SPOCK    = 3'd3;
  localparam logic [2:0] MV_LIZARD   = 3'd4;

  localparam logic [1:0] RES_DRAW    = 2'b00;
  localparam logic [1:0] RES_P1      = 2'b01;
  localparam logic [1:0] RES_P2      = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

`ifdef RPS_LIZARD_SPOCK_EN
  localparam int unsigned NUM_MOVES = 5;
`else
  localparam int unsigned NUM_MOVES = 3;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_JUDGE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tt_rps_match_if.sv
// Pin bundle of the RPS match tile, as seen by a driver and by the tile.
// No configuration macros.
interface tt_rps_match_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/rps_judge.sv
// Combinational round judge: validity check plus modular winner rule.
// RPS_LIZARD_SPOCK_EN selects the 5-move rule, else classic mod-3.
import rps_pkg::*;

module rps_judge (
  input  logic [2:0] p1_move,
  input  logic [2:0] p2_move,
  output logic [1:0] result
);

  localparam logic [3:0] NM = 4'(NUM_MOVES);

  logic       valid;
  logic       same;
  logic [3:0] diff;
  logic [3:0] dmod;
  logic       beats;
  logic       bad;
  logic       draw;
  logic       p1w;
  logic       p2w;

  assign valid = ({1'b0, p1_move} < NM)
               && ({1'b0, p2_move} < NM);
  assign same  = (p1_move == p2_move);
  assign diff  = {1'b0, p1_move} + NM
               - {1'b0, p2_move};
  assign dmod  = diff % NM;

`ifdef RPS_LIZARD_SPOCK_EN
  assign beats = (dmod == 4'd1) || (dmod == 4'd3);
`else
  assign beats = (dmod == 4'd1);
`endif

  // one-hot so the decoder below stays truly unique
  assign bad  = ~valid;
  assign draw = valid & same;
  assign p1w  = valid & ~same & beats;
  assign p2w  = valid & ~same & ~beats;

  always_comb begin
    result = RES_DRAW;
    unique case (1'b1)
      bad:  result = RES_INVALID;
      draw: result = RES_DRAW;
      p1w:  result = RES_P1;
      p2w:  result = RES_P2;
      default: result = RES_DRAW;
    endcase
  end

endmodule

// File: rtl/tt_rps_match.sv
// Rock-paper-scissors match: commit edge detect, judge FSM, scores.
// RPS_LIZARD_SPOCK_EN (via rps_pkg/rps_judge) enables spock and lizard.
import rps_pkg::*;

module tt_rps_match #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [SCORE_W-1:0] TARGET =
    SCORE_W'(WIN_TARGET);

  state_t             state;
  logic               commit_q;
  logic [2:0]         mv1;
  logic [2:0]         mv2;
  logic [SCORE_W-1:0] s1;
  logic [SCORE_W-1:0] s2;
  logic [2:0]         rounds;
  logic [1:0]         result;
  logic               res_vld;
  logic               over;
  logic               winner;
  logic [1:0]         judged;

  logic               commit;
  logic               new_match;
  logic               commit_rise;
  logic [SCORE_W-1:0] s1_inc;
  logic [SCORE_W-1:0] s2_inc;
  logic               unused_ok;

  assign commit      = ui_in[6];
  assign new_match   = ui_in[7];
  assign commit_rise = commit & ~commit_q;
  assign s1_inc      = s1 + 1'b1;
  assign s2_inc      = s2 + 1'b1;
  assign unused_ok   = &{1'b0, uio_in};

  rps_judge u_judge (
    .p1_move (mv1),
    .p2_move (mv2),
    .result  (judged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      commit_q <= 1'b0;
      mv1      <= '0;
      mv2      <= '0;
      s1       <= '0;
      s2       <= '0;
      rounds   <= '0;
      result   <= RES_DRAW;
      res_vld  <= 1'b0;
      over     <= 1'b0;
      winner   <= 1'b0;
    end else if (ena) begin
      // tracks commit in every state so a held commit never re-fires
      commit_q <= commit;
      if (new_match) begin
        state   <= ST_IDLE;
        s1      <= '0;
        s2      <= '0;
        rounds  <= '0;
        result  <= RES_DRAW;
        res_vld <= 1'b0;
        over    <= 1'b0;
        winner  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            res_vld <= 1'b0;
            if (commit_rise) begin
              mv1   <= ui_in[2:0];
              mv2   <= ui_in[5:3];
              state <= ST_JUDGE;
            end
          end
          ST_JUDGE: begin
            result  <= judged;
            res_vld <= 1'b1;
            rounds  <= rounds + 3'd1;
            state   <= ST_IDLE;
            if (judged == RES_P1) begin
              s1 <= s1_inc;
              if (s1_inc == TARGET) begin
                over   <= 1'b1;
                winner <= 1'b0;
                state  <= ST_DONE;
              end
            end else if (judged == RES_P2) begin
              s2 <= s2_inc;
              if (s2_inc == TARGET) begin
                over   <= 1'b1;
                winner <= 1'b1;
                state  <= ST_DONE;
              end
            end
          end
          ST_DONE: res_vld <= 1'b0;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign uo_out  = {rounds, winner, over,
                    res_vld, result};
  assign uio_out = {4'(s2), 4'(s1)};
  assign uio_oe  = 8'hFF;

endmodule

// File: doc/tt_rps_match.md
TT_RPS_MATCH -- requirements
Module: tt_rps_match

Interface
REQ-001 Parameter WIN_TARGET, default 3: round wins needed to take the match; legal range 1..15.
REQ-002 Parameter SCORE_W, default 4: score counter width; SHALL satisfy 2**SCORE_W > WIN_TARGET and SCORE_W <= 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  design enable; low freezes all registers, outputs hold their values.
REQ-006 ui_in  input  8  [2:0] P1 move, [5:3] P2 move, [6] commit, [7] new_match.
REQ-007 uo_out  output  8  [1:0] result, [2] result_valid, [3] match_over, [4] winner, [7:5] rounds played.
REQ-008 uio_in  input  8  unused, ignored.
REQ-009 uio_out  output  8  [3:0] P1 score, [7:4] P2 score, each zero-extended from SCORE_W.
REQ-010 uio_oe  output  8  SHALL be constant 8'hFF.

Function
REQ-011 Move codes: 0 rock, 1 paper, 2 scissors; 3 spock and 4 lizard only with RPS_LIZARD_SPOCK_EN; every other code is invalid.
REQ-012 Result codes: 00 draw, 01 P1 wins, 10 P2 wins, 11 invalid (either move invalid).
REQ-013 Winner rule: a beats b iff (a-b) mod 3 = 1 (classic), or (a-b) mod 5 in {1,3} (extended).
REQ-014 FSM states: IDLE, JUDGE, DONE.
REQ-015 A commit rising edge is commit=1 while the previous sampled commit=0; a commit_q register updates on every enabled edge in every state.
REQ-016 IDLE: on a commit rising edge, latch both moves and go to JUDGE.
REQ-017 JUDGE lasts exactly one cycle.
REQ-018 At the JUDGE exit edge: write result; pulse result_valid high for exactly one cycle; increment rounds (3-bit, wraps 7->0); increment the winner's score.
REQ-019 At the same edge: if the incremented score equals WIN_TARGET, set match_over=1 and winner (0=P1, 1=P2) and go to DONE, else go to IDLE.
REQ-020 Draw and invalid results change no score but still count a round.
REQ-021 Latency: commit high at edge N produces updated outputs after edge N+1.
REQ-022 DONE: commits are ignored, and results, scores and rounds hold.
REQ-023 new_match=1 at any enabled edge, in any state, clears scores, rounds, result, result_valid, match_over and winner, and enters IDLE.
REQ-024 new_match has priority over a simultaneous commit; that commit is discarded and is not replayed, because commit_q still updates.
REQ-025 A held commit SHALL produce exactly one round.
REQ-026 Moves changing after being latched SHALL NOT affect the judged result.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, commit_q 0, latched moves 0, scores 0, rounds 0, result 00, result_valid 0, match_over 0, winner 0.
REQ-028 After reset, uo_out=8'h00 and uio_out=8'h00.
REQ-029 Reset deassertion mid-round abandons the round with no score change.

Configuration
REQ-030 Macro RPS_LIZARD_SPOCK_EN defined: codes 3 and 4 are valid and the mod-5 rule applies.
REQ-031 RPS_LIZARD_SPOCK_EN undefined: codes 3..7 are invalid (result 11) and the mod-3 rule applies.

Structure
REQ-032 Package rps_pkg SHALL hold: move-code constants, result-code constants, the FSM state typedef, and NUM_MOVES (3 or 5, selected by the macro).
REQ-033 One sub-module, rps_judge, SHALL be purely combinational: two 3-bit moves in, 2-bit result out, containing all validity and winner logic.
REQ-034 The top level SHALL hold the FSM, edge detect, counters and output registers.

Verification
REQ-035 Reset, then P1=paper(1), P2=rock(0), commit pulse -> two edges later uo_out[1:0]=01, result_valid pulses one cycle, P1 score=1, rounds=1.
REQ-036 P1=rock, P2=rock -> result 00, scores unchanged, rounds increments.
REQ-037 P1 move 3, macro undefined -> result 11 and no score change; macro defined, P1=spock(3), P2=scissors(2) -> result 01.
REQ-038 P2 wins three rounds, WIN_TARGET=3 -> match_over=1, winner=1, P2 score=3; a further commit changes nothing.
REQ-039 Commit and new_match high on the same edge during a match -> all counters 0, state IDLE, no round recorded; commit held high afterwards produces no round.
REQ-040 Eight draws -> rounds wraps to 0; ena=0 during a commit -> no change until ena returns and a fresh rising edge occurs.
